// File: rtl/poly_seg_seq_if.sv
// Command/sample bus of the polynomial segment sequencer.
// The slave modport is the sequencer's view; the master modport drives commands and observes samples.
interface poly_seg_seq_if #(
  parameter int BC = 16,
  parameter int BT = 16,
  parameter int BN = 16
);
  logic          s_valid, s_ready;
  logic [BC-1:0] s_c0, s_c1, s_c2, s_c3, s_c4, s_c5;
  logic [BN-1:0] s_n;
  logic [BT-1:0] s_dt;
  logic [BT-1:0] m_t;
  logic [BC-1:0] m_c0, m_c1, m_c2, m_c3, m_c4, m_c5;
  logic          y_valid, y_last, busy;

  modport slave (
    input  s_valid, s_c0, s_c1, s_c2, s_c3, s_c4, s_c5, s_n, s_dt,
    output s_ready, m_t, m_c0, m_c1, m_c2, m_c3, m_c4, m_c5, y_valid, y_last, busy
  );
  modport master (
    output s_valid, s_c0, s_c1, s_c2, s_c3, s_c4, s_c5, s_n, s_dt,
    input  s_ready, m_t, m_c0, m_c1, m_c2, m_c3, m_c4, m_c5, y_valid, y_last, busy
  );
endinterface

// File: rtl/poly_seg_seq.sv
// Segment sequencer for the 5th-order polynomial evaluator: ramps t, skews coefficients per MAC stage, tags valid/last.
// Optional POLY_SEG_SEQ_STATS_EN adds underrun_cnt / seg_cnt counters.
module poly_seg_dly #(
  parameter int W = 16,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [D-1:0][W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];
endmodule

module poly_seg_seq #(
  parameter int BC        = 16,
  parameter int BT        = 16,
  parameter int BN        = 16,
  parameter int STAGE_LAT = 2,
  parameter int NSTAGE    = 5,
  parameter int OUT_LAT   = 1
) (
  input logic          clk,
  input logic          rst,
  poly_seg_seq_if.slave io
`ifdef POLY_SEG_SEQ_STATS_EN
  ,
  output logic [15:0]  underrun_cnt,
  output logic [15:0]  seg_cnt
`endif
);
  localparam int NC = NSTAGE + 1;
  localparam int L  = NSTAGE*STAGE_LAT + OUT_LAT;

  // c5 and c4 both feed stage 0; each later coefficient waits one more stage.
  function automatic int skew(int k);
    return (k >= NSTAGE-1) ? 0 : (NSTAGE-1-k)*STAGE_LAT;
  endfunction

  typedef enum logic {IDLE, RUN} st_t;

  st_t                   st;
  logic                  rdy_en, sh_full;
  logic [NC-1:0][BC-1:0] cmd_c, sh_c, act_c, dly_q;
  logic [BN-1:0]         sh_n, cnt;
  logic [BT-1:0]         sh_dt, dt, t_acc;
  logic [L:0]            vld_pipe, lst_pipe;
  logic                  take, sh_go, sh_drop, issue, fin, load, busy;

  assign cmd_c   = {io.s_c5, io.s_c4, io.s_c3, io.s_c2, io.s_c1, io.s_c0};
  assign io.s_ready = rdy_en & ~sh_full;
  assign take    = io.s_valid & io.s_ready;
  assign sh_go   = sh_full & (sh_n != '0);
  assign sh_drop = sh_full & (sh_n == '0);
  assign issue   = (st == RUN);
  assign fin     = issue & (cnt == BN'(1));
  // Loading alongside the last issue gives zero-gap back-to-back segments.
  assign load    = sh_go & ((st == IDLE) | fin);
  assign busy    = (st == RUN) | (|vld_pipe);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      rdy_en   <= 1'b0;
      sh_full  <= 1'b0;
      sh_c     <= '0;
      sh_n     <= '0;
      sh_dt    <= '0;
      act_c    <= '0;
      dt       <= '0;
      cnt      <= '0;
      t_acc    <= '0;
      io.m_t   <= '0;
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (take) begin
        sh_full <= 1'b1;
        sh_c    <= cmd_c;
        sh_n    <= io.s_n;
        sh_dt   <= io.s_dt;
      end else if (load | sh_drop) begin
        sh_full <= 1'b0;
      end
      if (issue) begin
        io.m_t <= t_acc;
        t_acc  <= t_acc + dt;
        cnt    <= cnt - BN'(1);
      end
      if (load) begin
        act_c <= sh_c;
        dt    <= sh_dt;
        cnt   <= sh_n;
        t_acc <= '0;
        st    <= RUN;
      end else if (fin) begin
        st <= IDLE;
      end
      vld_pipe <= {vld_pipe[L-1:0], issue};
      lst_pipe <= {lst_pipe[L-1:0], fin};
    end
  end

  for (genvar k = 0; k < NC; k++) begin : g_lane
    poly_seg_dly #(.W(BC), .D(skew(k) + 1)) u_dly (
      .clk (clk),
      .rst (rst),
      .d   (act_c[k]),
      .q   (dly_q[k])
    );
  end

  assign io.m_c0    = dly_q[0];
  assign io.m_c1    = dly_q[1];
  assign io.m_c2    = dly_q[2];
  assign io.m_c3    = dly_q[3];
  assign io.m_c4    = dly_q[4];
  assign io.m_c5    = dly_q[5];
  assign io.y_valid = vld_pipe[L];
  assign io.y_last  = lst_pipe[L];
  assign io.busy    = busy;

`ifdef POLY_SEG_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
      seg_cnt      <= '0;
    end else begin
      if ((st == IDLE) && busy && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
      if (load) seg_cnt <= seg_cnt + 16'd1;
    end
  end
`endif
endmodule
